// File: rtl/lal_scan_ctrl.sv
// lal_scan_ctrl: sequencing controller for the lal step-counter/compare datapath.
// Latches a key and steps an index from 0 to LIMIT. At each step it reads one
// table entry and compares it with the key. The scan ends on the first match,
// at LIMIT, or on abort, and the result is then held until it is accepted.
module lal_scan_ctrl #(
  parameter int CNT_W = 9,
  parameter int KEY_W = 4,
  parameter int LIMIT = 511
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [KEY_W-1:0] key,
  input  logic             hold,
  input  logic             abort,
  output logic             tbl_rd,
  output logic [CNT_W-1:0] tbl_addr,
  input  logic [KEY_W-1:0] tbl_data,
  output logic             done_valid,
  input  logic             done_ready,
  output logic             done_hit,
  output logic             done_abort,
  output logic [CNT_W-1:0] done_idx,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] LIM = CNT_W'(LIMIT);
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  state_t           state, state_nx;
  logic [CNT_W-1:0] idx, idx_nx;
  logic [KEY_W-1:0] key_q, key_nx;
  logic             hit_nx, abt_nx;
  logic [CNT_W-1:0] didx_nx;

  // The state register, the scan index, the latched key and the held result fields.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      idx        <= {CNT_W{1'b0}};
      key_q      <= {KEY_W{1'b0}};
      done_hit   <= 1'b0;
      done_abort <= 1'b0;
      done_idx   <= {CNT_W{1'b0}};
    end else begin
      state      <= state_nx;
      idx        <= idx_nx;
      key_q      <= key_nx;
      done_hit   <= hit_nx;
      done_abort <= abt_nx;
      done_idx   <= didx_nx;
    end
  end

  // Next-state logic and the table strobe. Within SCAN, abort wins over hold,
  // and hold wins over compare. The index is compared with LIMIT before it is
  // incremented, so it never passes LIMIT.
  always_comb begin
    state_nx = state;
    idx_nx   = idx;
    key_nx   = key_q;
    hit_nx   = done_hit;
    abt_nx   = done_abort;
    didx_nx  = done_idx;
    tbl_rd   = 1'b0;
    case (state)
      IDLE: begin
        if (start_valid) begin
          key_nx   = key;
          idx_nx   = {CNT_W{1'b0}};
          state_nx = SCAN;
        end else begin
          state_nx = IDLE;
        end
      end
      SCAN: begin
        if (abort) begin
          state_nx = RESP;
          hit_nx   = 1'b0;
          abt_nx   = 1'b1;
          didx_nx  = idx;
        end else if (hold) begin
          state_nx = SCAN;
        end else begin
          tbl_rd = 1'b1;
          if (tbl_data == key_q) begin
            state_nx = RESP;
            hit_nx   = 1'b1;
            abt_nx   = 1'b0;
            didx_nx  = idx;
          end else if (idx == LIM) begin
            state_nx = RESP;
            hit_nx   = 1'b0;
            abt_nx   = 1'b0;
            didx_nx  = LIM;
          end else begin
            idx_nx = idx + ONE;
          end
        end
      end
      RESP: begin
        if (done_ready) begin
          state_nx = IDLE;
        end else begin
          state_nx = RESP;
        end
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  assign tbl_addr    = idx;
  assign start_ready = (state == IDLE);
  assign busy        = (state != IDLE);
  assign done_valid  = (state == RESP);

endmodule

// File: tb/tb_lal_scan_ctrl.sv
// Directed bench for lal_scan_ctrl. It uses LIMIT=7 and an 8-entry table model.
module tb_lal_scan_ctrl;

  localparam int CNT_W = 9;
  localparam int KEY_W = 4;
  localparam int LIMIT = 7;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start_valid = 1'b0;
  logic             start_ready;
  logic [KEY_W-1:0] key = 4'h0;
  logic             hold = 1'b0;
  logic             abort = 1'b0;
  logic             tbl_rd;
  logic [CNT_W-1:0] tbl_addr;
  logic [KEY_W-1:0] tbl_data;
  logic             done_valid;
  logic             done_ready = 1'b0;
  logic             done_hit;
  logic             done_abort;
  logic [CNT_W-1:0] done_idx;
  logic             busy;

  logic [KEY_W-1:0] mem [0:7];
  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  assign tbl_data = mem[tbl_addr[2:0]];

  lal_scan_ctrl #(.CNT_W(CNT_W), .KEY_W(KEY_W), .LIMIT(LIMIT)) dut (
    .clk(clk), .rst(rst),
    .start_valid(start_valid), .start_ready(start_ready), .key(key),
    .hold(hold), .abort(abort),
    .tbl_rd(tbl_rd), .tbl_addr(tbl_addr), .tbl_data(tbl_data),
    .done_valid(done_valid), .done_ready(done_ready),
    .done_hit(done_hit), .done_abort(done_abort), .done_idx(done_idx),
    .busy(busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Idle outputs.
  task automatic chk_idle(input string tag);
    chk({tag, ".start_ready"}, 32'(start_ready), 32'd1);
    chk({tag, ".busy"},        32'(busy),        32'd0);
    chk({tag, ".done_valid"},  32'(done_valid),  32'd0);
    chk({tag, ".tbl_rd"},      32'(tbl_rd),      32'd0);
  endtask

  // Scan-cycle outputs: read strobe and address.
  task automatic chk_scan(input string tag, input logic rd, input int addr);
    chk({tag, ".tbl_rd"},      32'(tbl_rd),      32'(rd));
    chk({tag, ".tbl_addr"},    32'(tbl_addr),    32'(addr));
    chk({tag, ".done_valid"},  32'(done_valid),  32'd0);
    chk({tag, ".busy"},        32'(busy),        32'd1);
    chk({tag, ".start_ready"}, 32'(start_ready), 32'd0);
  endtask

  // Result beat.
  task automatic chk_done(input string tag, input logic hit, input logic abt, input int idx);
    chk({tag, ".done_valid"}, 32'(done_valid), 32'd1);
    chk({tag, ".done_hit"},   32'(done_hit),   32'(hit));
    chk({tag, ".done_abort"}, 32'(done_abort), 32'(abt));
    chk({tag, ".done_idx"},   32'(done_idx),   32'(idx));
    chk({tag, ".tbl_rd"},     32'(tbl_rd),     32'd0);
  endtask

  task automatic do_start(input logic [KEY_W-1:0] k);
    start_valid = 1'b1;
    key = k;
    tick();
    start_valid = 1'b0;
    key = 4'h0;
  endtask

  task automatic accept(input string tag);
    done_ready = 1'b1;
    tick();
    done_ready = 1'b0;
    #1;
    chk_idle(tag);
  endtask

  initial begin
    for (int i = 0; i < 8; i++) mem[i] = 4'h0;
    mem[5] = 4'hA;

    // 1: reset and idle.
    tick();
    tick();
    rst = 1'b0;
    #1;
    chk_idle("rst");
    chk("rst.tbl_addr", 32'(tbl_addr), 32'd0);
    chk("rst.done_hit", 32'(done_hit), 32'd0);
    tick();
    chk_idle("idle");

    // 2: key A matches at index 5; done_valid in cycle 7.
    do_start(4'hA);
    for (int c = 1; c <= 6; c++) begin
      #1;
      chk_scan("hit5.scan", 1'b1, c - 1);
      tick();
    end
    chk_done("hit5", 1'b1, 1'b0, 5);
    accept("hit5.acc");

    // 3: miss; reads indices 0..7 and stops at LIMIT.
    do_start(4'h3);
    for (int c = 1; c <= 8; c++) begin
      #1;
      chk_scan("miss.scan", 1'b1, c - 1);
      tick();
    end
    chk_done("miss", 1'b0, 1'b0, 7);
    chk("miss.tbl_addr", 32'(tbl_addr), 32'd7);
    accept("miss.acc");

    // 4: match at index 4; hold for 3 cycles at idx 2; done in cycle 9.
    mem[4] = 4'hB;
    do_start(4'hB);
    #1; chk_scan("hold.c1", 1'b1, 0); tick();
    #1; chk_scan("hold.c2", 1'b1, 1); tick();
    hold = 1'b1;
    for (int c = 3; c <= 5; c++) begin
      #1;
      chk_scan("hold.frozen", 1'b0, 2);
      tick();
    end
    hold = 1'b0;
    for (int c = 6; c <= 8; c++) begin
      #1;
      chk_scan("hold.resume", 1'b1, c - 4);
      tick();
    end
    chk_done("hold", 1'b1, 1'b0, 4);
    accept("hold.acc");

    // 5: abort at idx 3 with hold also high; the result is held while done_ready is low.
    do_start(4'h3);
    for (int c = 1; c <= 3; c++) begin
      #1;
      chk_scan("abt.scan", 1'b1, c - 1);
      tick();
    end
    abort = 1'b1;
    hold = 1'b1;
    #1;
    chk_scan("abt.c4", 1'b0, 3);
    tick();
    abort = 1'b0;
    hold = 1'b0;
    for (int w = 0; w < 4; w++) begin
      #1;
      chk_done("abt.held", 1'b0, 1'b1, 3);
      chk("abt.busy", 32'(busy), 32'd1);
      tick();
    end
    accept("abt.acc");

    // 6: reset mid-scan at idx 6 returns to idle with no done beat.
    do_start(4'h3);
    for (int c = 1; c <= 7; c++) begin
      #1;
      chk_scan("rst6.scan", 1'b1, c - 1);
      if (c < 7) tick();
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk_idle("rst6");
    chk("rst6.tbl_addr",   32'(tbl_addr),   32'd0);
    chk("rst6.done_abort", 32'(done_abort), 32'd0);
    chk("rst6.done_idx",   32'(done_idx),   32'd0);
    tick();
    tick();
    chk_idle("rst6.quiet");
    do_start(4'hA);
    for (int c = 1; c <= 6; c++) begin
      #1;
      chk_scan("rst6.rescan", 1'b1, c - 1);
      tick();
    end
    chk_done("rst6.hit", 1'b1, 1'b0, 5);
    accept("rst6.acc");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
